// File: rtl/crypt_pkg.sv
// Shared constants, frame field positions, FSM state type and checksum helper
// for the decrypt engine.
package crypt_pkg;

  localparam int RAW_W   = 60;
  localparam int ENC_W   = 78;
  localparam int SYM_W   = 6;
  localparam int NUM_SYM = 10;
  localparam int CNT_W   = 4;
  localparam int SUM_W   = 9;

  // Encrypted frame layout: {S6 salt, S9 salt, c9..c0, checksum}
  localparam int S6_LSB  = 72;
  localparam int S6_W    = 6;
  localparam int S9_LSB  = 63;
  localparam int S9_W    = 9;
  localparam int SYM_LSB = 3;
  localparam int CHK_LSB = 0;
  localparam int CHK_W   = 3;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    CHECK,
    DONE
  } stateT;

  function automatic logic [CHK_W-1:0] calcChecksum(input logic [SUM_W-1:0] sum,
                                                     input logic [S9_W-1:0]  s9);
    logic [SUM_W-1:0] total;
    total = sum + s9;
    return total[CHK_W-1:0];
  endfunction

endpackage

// File: rtl/decrypt_engine_if.sv
// Frame-in / result-out handshake bundle of the decrypt engine; master is the
// frame producer and result consumer, slave is the engine.
interface decrypt_engine_if;
  import crypt_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [ENC_W-1:0] enc_in;
  logic [RAW_W-1:0] password;
  logic             out_valid;
  logic             out_ready;
  logic [RAW_W-1:0] data_out;
  logic             err;

  modport master (
    output in_valid, enc_in, password, out_ready,
    input  in_ready, out_valid, data_out, err
  );

  modport slave (
    input  in_valid, enc_in, password, out_ready,
    output in_ready, out_valid, data_out, err
  );

endinterface

// File: rtl/sym_decode.sv
// Combinational single-symbol decoder: p = ((c - s6 - index) mod 64) ^ pw.
// Shared by the engine across all ten symbol positions.
module sym_decode
  import crypt_pkg::*;
(
  input  logic [SYM_W-1:0] c,
  input  logic [SYM_W-1:0] s6,
  input  logic [CNT_W-1:0] index,
  input  logic [SYM_W-1:0] pw,
  output logic [SYM_W-1:0] p
);

  logic [SYM_W-1:0] unsalted;

  // 6-bit arithmetic wraps naturally, so c < s6 + index needs no special case
  assign unsalted = c - s6 - {{(SYM_W-CNT_W){1'b0}}, index};
  assign p        = unsalted ^ pw;

endmodule

// File: rtl/decrypt_engine.sv
// Frame decrypt engine: one symbol per cycle through a shared sym_decode, with
// an optional checksum stage enabled by the DECRYPT_CHECKSUM_EN macro.
module decrypt_engine
  import crypt_pkg::*;
#(
  parameter bit CLR_ON_ERR = 1'b1
) (
  input  logic Clk,
  input  logic Rst,
  decrypt_engine_if.slave bus
);

  stateT                    state;
  stateT                    stateNext;
  logic [CNT_W-1:0]         symCnt;
  logic [S6_W-1:0]          s6Reg;
  logic [NUM_SYM*SYM_W-1:0] cipherReg;
  logic [RAW_W-1:0]         pwReg;
  logic [RAW_W-1:0]         dataReg;
  logic [SYM_W-1:0]         symC;
  logic [SYM_W-1:0]         symPw;
  logic [SYM_W-1:0]         symP;
  logic                     accept;
  logic                     lastSym;
  logic                     errFlag;

  assign accept  = bus.in_valid && (state == IDLE);
  assign lastSym = (symCnt == CNT_W'(NUM_SYM - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= stateNext;
  end

  // NOTE: every output of this block is defaulted first so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    stateNext     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (accept) stateNext = DECODE;
      end
      DECODE: begin
`ifdef DECRYPT_CHECKSUM_EN
        if (lastSym) stateNext = CHECK;
`else
        if (lastSym) stateNext = DONE;
`endif
      end
      CHECK: stateNext = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Select the current symbol and key slice for the shared decoder
  always_comb begin
    symC  = '0;
    symPw = '0;
    for (int k = 0; k < NUM_SYM; k++) begin
      if (symCnt == CNT_W'(k)) begin
        symC  = cipherReg[k*SYM_W +: SYM_W];
        symPw = pwReg[k*SYM_W +: SYM_W];
      end
    end
  end

  sym_decode symDecode (
    .c     (symC),
    .s6    (s6Reg),
    .index (symCnt),
    .pw    (symPw),
    .p     (symP)
  );

  // NOTE: the frame registers are reset as well, so an aborted frame can
  // never surface as stale output later.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      symCnt    <= '0;
      s6Reg     <= '0;
      cipherReg <= '0;
      pwReg     <= '0;
      dataReg   <= '0;
    end else if (accept) begin
      symCnt    <= '0;
      s6Reg     <= bus.enc_in[S6_LSB +: S6_W];
      cipherReg <= bus.enc_in[SYM_LSB +: NUM_SYM*SYM_W];
      pwReg     <= bus.password;
      dataReg   <= '0;
    end else if (state == DECODE) begin
      symCnt <= symCnt + CNT_W'(1);
      for (int k = 0; k < NUM_SYM; k++) begin
        if (symCnt == CNT_W'(k)) dataReg[k*SYM_W +: SYM_W] <= symP;
      end
    end
  end

`ifdef DECRYPT_CHECKSUM_EN
  logic [SUM_W-1:0] sumReg;
  logic [S9_W-1:0]  s9Reg;
  logic [CHK_W-1:0] chkReg;
  logic             errReg;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sumReg <= '0;
      s9Reg  <= '0;
      chkReg <= '0;
      errReg <= 1'b0;
    end else if (accept) begin
      sumReg <= '0;
      s9Reg  <= bus.enc_in[S9_LSB +: S9_W];
      chkReg <= bus.enc_in[CHK_LSB +: CHK_W];
      errReg <= 1'b0;
    end else if (state == DECODE) begin
      sumReg <= sumReg + SUM_W'(symP);
    end else if (state == CHECK) begin
      errReg <= (calcChecksum(sumReg, s9Reg) != chkReg);
    end
  end

  assign errFlag = errReg;
`else
  assign errFlag = 1'b0;
`endif

  // Results are only visible in DONE; an errored result may be blanked
  assign bus.err      = (state == DONE) && errFlag;
  assign bus.data_out = ((state == DONE) && !(CLR_ON_ERR && errFlag)) ? dataReg : '0;

endmodule

// File: tb/tb_decrypt_engine.sv
// Directed self-checking bench for decrypt_engine; expectations follow the
// DECRYPT_CHECKSUM_EN setting used for the build.
module tb_decrypt_engine;
  import crypt_pkg::*;

`ifdef DECRYPT_CHECKSUM_EN
  localparam int EXP_LAT = 12;
  localparam bit CHK_ON  = 1'b1;
`else
  localparam int EXP_LAT = 11;
  localparam bit CHK_ON  = 1'b0;
`endif
  localparam int MAX_WAIT = 40;

  // c_i = i, c_i = i + 1 (also used as key pw_i = i + 1), and the wrap result
  localparam logic [RAW_W-1:0] SYM_I  = {6'd9, 6'd8, 6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1, 6'd0};
  localparam logic [RAW_W-1:0] SEQ_1  = {6'd10, 6'd9, 6'd8, 6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1};
  localparam logic [RAW_W-1:0] WRAP_P = {6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1, 6'd0, 6'd63, 6'd62};

  typedef struct {
    logic [ENC_W-1:0] enc;
    logic [RAW_W-1:0] pw;
    logic [RAW_W-1:0] data;
    logic             err;
  } vecT;

  logic Clk = 1'b0;
  logic Rst;
  int   passCnt  = 0;
  int   totalCnt = 0;

  always #5 Clk = ~Clk;

  decrypt_engine_if bus ();

  decrypt_engine #(.CLR_ON_ERR(1'b1)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  function automatic logic [ENC_W-1:0] mkEnc(input logic [5:0] s6, input logic [8:0] s9,
                                             input logic [RAW_W-1:0] syms, input logic [2:0] chk);
    return {s6, s9, syms, chk};
  endfunction

  // Start a frame from IDLE, return cycles from accept until out_valid
  task automatic runFrame(input logic [ENC_W-1:0] enc, input logic [RAW_W-1:0] pw, output int lat);
    bus.enc_in   = enc;
    bus.password = pw;
    bus.in_valid = 1'b1;
    @(posedge Clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < MAX_WAIT) begin
      @(posedge Clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.enc_in    = '0;
    bus.password  = '0;
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    totalCnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); else passCnt++;
    totalCnt++; if (bus.data_out !== '0) $display("FAIL reset_data_out: got %h expected 0", bus.data_out); else passCnt++;
    totalCnt++; if (bus.err !== 1'b0) $display("FAIL reset_err: got %b expected 0", bus.err); else passCnt++;
    Rst = 1'b0;
    @(posedge Clk); #1;
    totalCnt++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); else passCnt++;
  endtask

  task automatic test_decode();
    vecT vecs[7];
    int  lat;
    vecs[0] = '{mkEnc(6'd0, 9'd0, SYM_I, 3'd0), '0, '0, 1'b0};
    vecs[1] = '{mkEnc(6'd1, 9'd0, SEQ_1, 3'd0), '0, '0, 1'b0};
    vecs[2] = '{mkEnc(6'd0, 9'd0, SYM_I, 3'd3), '0, '0, CHK_ON};
    vecs[3] = '{mkEnc(6'd0, 9'd0, SYM_I, 3'd7), SEQ_1, SEQ_1, 1'b0};
    vecs[4] = '{mkEnc(6'd0, 9'd0, SYM_I, 3'd0), SEQ_1, CHK_ON ? '0 : SEQ_1, CHK_ON};
    vecs[5] = '{mkEnc(6'd0, 9'd3, SYM_I, 3'd2), SEQ_1, SEQ_1, 1'b0};
    vecs[6] = '{mkEnc(6'd63, 9'd0, '0, 3'd1), '1, WRAP_P, 1'b0};
    bus.out_ready = 1'b1;
    for (int v = 0; v < 7; v++) begin
      runFrame(vecs[v].enc, vecs[v].pw, lat);
      totalCnt++; if (lat !== EXP_LAT) $display("FAIL decode%0d_latency: got %0d expected %0d", v, lat, EXP_LAT); else passCnt++;
      totalCnt++; if (bus.data_out !== vecs[v].data) $display("FAIL decode%0d_data: got %h expected %h", v, bus.data_out, vecs[v].data); else passCnt++;
      totalCnt++; if (bus.err !== vecs[v].err) $display("FAIL decode%0d_err: got %b expected %b", v, bus.err, vecs[v].err); else passCnt++;
      @(posedge Clk); #1;
      totalCnt++; if (bus.in_ready !== 1'b1) $display("FAIL decode%0d_return_idle: got %b expected 1", v, bus.in_ready); else passCnt++;
    end
  endtask

  task automatic test_hold();
    int lat;
    bit seen;
    bus.out_ready = 1'b0;
    runFrame(mkEnc(6'd0, 9'd0, SYM_I, 3'd7), SEQ_1, lat);
    totalCnt++; if (lat !== EXP_LAT) $display("FAIL hold_latency: got %0d expected %0d", lat, EXP_LAT); else passCnt++;
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = (c == 1);
      bus.enc_in   = mkEnc(6'd63, 9'd0, '0, 3'd1);
      bus.password = '1;
      @(posedge Clk); #1;
      totalCnt++; if (bus.out_valid !== 1'b1) $display("FAIL hold%0d_out_valid: got %b expected 1", c, bus.out_valid); else passCnt++;
      totalCnt++; if (bus.in_ready !== 1'b0) $display("FAIL hold%0d_in_ready: got %b expected 0", c, bus.in_ready); else passCnt++;
      totalCnt++; if (bus.data_out !== SEQ_1) $display("FAIL hold%0d_data: got %h expected %h", c, bus.data_out, SEQ_1); else passCnt++;
      totalCnt++; if (bus.err !== 1'b0) $display("FAIL hold%0d_err: got %b expected 0", c, bus.err); else passCnt++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge Clk); #1;
    totalCnt++; if (bus.out_valid !== 1'b0) $display("FAIL hold_release_out_valid: got %b expected 0", bus.out_valid); else passCnt++;
    seen = 1'b0;
    repeat (15) begin
      @(posedge Clk); #1;
      if (bus.out_valid === 1'b1 || bus.in_ready !== 1'b1) seen = 1'b1;
    end
    totalCnt++; if (seen !== 1'b0) $display("FAIL hold_pulse_captured: got busy=%b expected 0", seen); else passCnt++;
  endtask

  task automatic test_abort();
    int lat;
    bit seen;
    bus.out_ready = 1'b1;
    bus.enc_in    = mkEnc(6'd0, 9'd0, SYM_I, 3'd7);
    bus.password  = SEQ_1;
    bus.in_valid  = 1'b1;
    @(posedge Clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    totalCnt++; if (bus.in_ready !== 1'b1) $display("FAIL abort_in_ready: got %b expected 1", bus.in_ready); else passCnt++;
    totalCnt++; if (bus.data_out !== '0) $display("FAIL abort_data_out: got %h expected 0", bus.data_out); else passCnt++;
    seen = 1'b0;
    repeat (20) begin
      @(posedge Clk); #1;
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    totalCnt++; if (seen !== 1'b0) $display("FAIL abort_out_valid_rose: got %b expected 0", seen); else passCnt++;
    runFrame(mkEnc(6'd63, 9'd0, '0, 3'd1), '1, lat);
    totalCnt++; if (lat !== EXP_LAT) $display("FAIL abort_next_latency: got %0d expected %0d", lat, EXP_LAT); else passCnt++;
    totalCnt++; if (bus.data_out !== WRAP_P) $display("FAIL abort_next_data: got %h expected %h", bus.data_out, WRAP_P); else passCnt++;
    totalCnt++; if (bus.err !== 1'b0) $display("FAIL abort_next_err: got %b expected 0", bus.err); else passCnt++;
    @(posedge Clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat;
    bus.out_ready = 1'b1;
    bus.enc_in    = mkEnc(6'd0, 9'd3, SYM_I, 3'd2);
    bus.password  = SEQ_1;
    bus.in_valid  = 1'b1;
    @(posedge Clk); #1;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < MAX_WAIT) begin
      @(posedge Clk); #1;
      lat++;
    end
    totalCnt++; if (lat !== EXP_LAT) $display("FAIL b2b_first_latency: got %0d expected %0d", lat, EXP_LAT); else passCnt++;
    totalCnt++; if (bus.data_out !== SEQ_1) $display("FAIL b2b_first_data: got %h expected %h", bus.data_out, SEQ_1); else passCnt++;
    bus.enc_in   = mkEnc(6'd63, 9'd0, '0, 3'd1);
    bus.password = '1;
    @(posedge Clk); #1;
    totalCnt++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      $display("FAIL b2b_idle_gap: got in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid); else passCnt++;
    @(posedge Clk); #1;
    bus.in_valid = 1'b0;
    totalCnt++; if (bus.in_ready !== 1'b0) $display("FAIL b2b_second_accept: got in_ready=%b expected 0", bus.in_ready); else passCnt++;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < MAX_WAIT) begin
      @(posedge Clk); #1;
      lat++;
    end
    totalCnt++; if (lat !== EXP_LAT) $display("FAIL b2b_second_latency: got %0d expected %0d", lat, EXP_LAT); else passCnt++;
    totalCnt++; if (bus.data_out !== WRAP_P) $display("FAIL b2b_second_data: got %h expected %h", bus.data_out, WRAP_P); else passCnt++;
    @(posedge Clk); #1;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_hold();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/decrypt_engine.md
DECRYPT_ENGINE -- requirements
Module: decrypt_engine

Interface
REQ-001 Parameter CLR_ON_ERR, default 1: when 1, data_out is forced to zero whenever err is 1.
REQ-002 Clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  enc_in is valid this cycle.
REQ-005 in_ready  output  1  engine can accept a frame.
REQ-006 enc_in  input  78  encrypted frame: [77:72] S6 salt, [71:63] S9 salt, [62:3] ciphertext symbols c9..c0 (c_i = [6i+8:6i+3]), [2:0] checksum.
REQ-007 password  input  60  key; pw_i = password[6i+5:6i]; sampled only at frame accept.
REQ-008 out_valid  output  1  data_out and err are valid.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 data_out  output  60  recovered raw data; p_i at [6i+5:6i].
REQ-011 err  output  1  checksum mismatch on the current result.

Function
REQ-012 Frame accept shall occur on a cycle where in_valid and in_ready are both 1; enc_in and password are captured into internal registers that cycle.
REQ-013 in_ready shall be 1 only in state IDLE.
REQ-014 States: IDLE, DECODE, CHECK, DONE; IDLE->DECODE on accept; DECODE->CHECK after symbol 9; CHECK->DONE; DONE->IDLE when out_ready is 1.
REQ-015 DECODE shall process exactly one symbol per cycle, i = 0..9 in ascending order, using a 4-bit symbol counter cleared on accept.
REQ-016 Symbol decode: p_i = ((c_i - S6 - i) mod 64) XOR pw_i, all arithmetic 6-bit wrap-around.
REQ-017 A 9-bit running sum shall accumulate p_i during DECODE; expected checksum = (sum + S9) mod 8.
REQ-018 CHECK shall set err = 1 if the expected checksum differs from enc_in[2:0], else 0.
REQ-019 out_valid shall be 1 only in DONE; data_out and err shall hold stable while out_valid=1 and out_ready=0.
REQ-020 Latency: with accept at cycle T, out_valid shall rise at T+12 (checksum enabled) or at T+11 (checksum disabled).
REQ-021 With out_ready held at 1, a new frame shall be accepted no earlier than the cycle after the DONE->IDLE transition; there is no overlap of frames.
REQ-022 in_valid while the engine is busy shall be ignored; the frame is not captured.
REQ-023 c_i < S6 + i shall wrap modulo 64, with no error raised.

Reset
REQ-024 While Rst=1: state = IDLE, counter = 0, sum = 0, in_ready = 1 from the first cycle after reset is released, and out_valid, data_out and err = 0.
REQ-025 Rst asserted in DECODE, CHECK or DONE shall abort the frame with no partial output, and the engine returns to the REQ-024 values.

Configuration
REQ-026 Macro DECRYPT_CHECKSUM_EN defined: CHECK state and err are implemented as in REQ-017/018.
REQ-027 Macro DECRYPT_CHECKSUM_EN undefined: the sum register and CHECK state are omitted, DECODE goes directly to DONE, err is tied to 0, and enc_in[2:0] is ignored.

Structure
REQ-028 Package crypt_pkg shall hold the RAW_W=60, ENC_W=78, SYM_W=6, NUM_SYM=10 constants, the salt and checksum field-position constants, and the state enum type.
REQ-029 Sub-module sym_decode shall be purely combinational, taking (c, S6, index, pw) and returning p; it is instantiated once and time-shared across the 10 symbols.

Verification
REQ-030 password=0, S6=0, S9=0, c_i=i, chk=0 -> data_out=0, err=0, out_valid at T+12.
REQ-031 password=0, S6=1, S9=0, c_i=i+1, chk=0 -> data_out=0, err=0; covers the S6 subtraction.
REQ-032 Same frame as REQ-030 with chk=3 -> err=1; data_out=0 with CLR_ON_ERR=1; with DECRYPT_CHECKSUM_EN undefined -> err=0 and out_valid at T+11.
REQ-033 password=all ones (pw_i=63), S6=63, S9=0, c_0=0 -> p_0=((0-63) mod 64) XOR 63=62; covers wrap-around.
REQ-034 Hold out_ready=0 for 5 cycles in DONE and pulse in_valid meanwhile -> outputs stay stable, the pulsed frame is not captured, and in_ready stays 0.
REQ-035 Assert Rst at accept+5 -> out_valid never rises for that frame; the next frame decodes correctly.
